timer_ctrl: RTL and testbench



---
 rtl/timer_pkg.sv | 19 +
 rtl/digit_entry_sreg.sv | 38 +++
 rtl/timer_ctrl.sv | 111 +++++++++++
 tb/tb_timer_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer controller.
// State encoding, BCD limits and alarm counter width.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    PAUSE = 3'd4,
    DONE  = 3'd5,
    CLEAR = 3'd6
  } state_t;

  localparam int DIGIT_MAX = 9;
  localparam int TENS_MAX  = 5;
  localparam int ACNT_W    = 4;

endpackage

// File: rtl/digit_entry_sreg.sv
// Three-digit BCD entry shift register.
// Rejects non-BCD keys and clamps the seconds-tens digit.
module digit_entry_sreg
  import timer_pkg::*;
#(
  parameter int MAX_TENS = TENS_MAX
) (
  input  logic       clock,
  input  logic       clr,
  input  logic       clear,
  input  logic       en,
  input  logic [3:0] digit,
  output logic       accept,
  output logic [3:0] min_q,
  output logic [3:0] tens_clamped,
  output logic [3:0] ones_q
);

  logic [3:0] tens_q;

  assign accept = en & (digit <= 4'(DIGIT_MAX));

  always_ff @(posedge clock) begin
    if (clr || clear) begin
      min_q  <= '0;
      tens_q <= '0;
      ones_q <= '0;
    end else if (accept) begin
      min_q  <= tens_q;
      tens_q <= ones_q;
      ones_q <= digit;
    end
  end

  assign tens_clamped =
    (tens_q > 4'(MAX_TENS)) ? 4'(MAX_TENS) : tens_q;

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer sequencer: entry, load, run, pause, alarm.
// Drives the shared load strobe and gates the 1 Hz enable.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int ALARM_TICKS = 5,
  parameter int MAX_TENS    = 5
) (
  input  logic       clock,
  input  logic       clr,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  input  logic       min_zero,
  input  logic       tens_zero,
  input  logic       ones_zero,
  output logic       loadn,
  output logic [3:0] min_data,
  output logic [3:0] tens_data,
  output logic [3:0] ones_data,
  output logic       cnt_en,
  output logic       running,
  output logic       alarm,
  output logic [2:0] state_o
);

  state_t            state, nstate;
  logic [ACNT_W-1:0] acnt;
  logic              in_entry;
  logic              all_zero;
  logic              accept;
  logic              clear_regs;

  assign in_entry = (state == IDLE) | (state == ENTRY);
  assign all_zero = min_zero & tens_zero & ones_zero;

  // Entry regs are wiped on cancel from entry or on the way into CLEAR
  assign clear_regs = stop & (in_entry | (state == PAUSE));

  digit_entry_sreg #(
    .MAX_TENS(MAX_TENS)
  ) u_sreg (
    .clock       (clock),
    .clr         (clr),
    .clear       (clear_regs),
    .en          (in_entry & digit_valid & ~start & ~stop),
    .digit       (digit),
    .accept      (accept),
    .min_q       (min_data),
    .tens_clamped(tens_data),
    .ones_q      (ones_data)
  );

  always_ff @(posedge clock) begin
    if (clr) state <= IDLE;
    else     state <= nstate;
  end

  always_ff @(posedge clock) begin
    if (clr)
      acnt <= '0;
    else if (state != DONE && nstate == DONE)
      acnt <= '0;
    else if (state == DONE && tick)
      acnt <= acnt + 1'b1;
  end

  always_comb begin
    nstate = state;
    loadn  = 1'b1;
    unique case (state)
      IDLE, ENTRY: begin
        if (stop)        nstate = IDLE;
        else if (start)  nstate = LOAD;
        else if (accept) nstate = ENTRY;
      end
      LOAD: begin
        loadn  = 1'b0;
        nstate = RUN;
      end
      RUN: begin
        if (stop)          nstate = PAUSE;
        else if (all_zero) nstate = DONE;
      end
      PAUSE: begin
        if (stop)       nstate = CLEAR;
        else if (start) nstate = RUN;
      end
      DONE: begin
        if (stop)
          nstate = IDLE;
        else if (tick &&
                 acnt == ACNT_W'(ALARM_TICKS - 1))
          nstate = IDLE;
      end
      CLEAR: begin
        loadn  = 1'b0;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  assign cnt_en  = tick & (state == RUN) & ~all_zero;
  assign running = (state == RUN);
  assign alarm   = (state == DONE);
  assign state_o = state;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed self-checking bench for timer_ctrl.
// Zero flags are driven directly to mimic the counter cascade.
module tb_timer_ctrl;

  logic       clock = 1'b0;
  logic       clr, tick, start, stop;
  logic [3:0] digit;
  logic       digit_valid;
  logic       min_zero, tens_zero, ones_zero;
  logic       loadn, cnt_en, running, alarm;
  logic [3:0] min_data, tens_data, ones_data;
  logic [2:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ENTRY = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_CLEAR = 3'd6;

  always #5 clock = ~clock;

  timer_ctrl #(
    .ALARM_TICKS(5),
    .MAX_TENS   (5)
  ) dut (
    .clock      (clock),
    .clr        (clr),
    .tick       (tick),
    .start      (start),
    .stop       (stop),
    .digit      (digit),
    .digit_valid(digit_valid),
    .min_zero   (min_zero),
    .tens_zero  (tens_zero),
    .ones_zero  (ones_zero),
    .loadn      (loadn),
    .min_data   (min_data),
    .tens_data  (tens_data),
    .ones_data  (ones_data),
    .cnt_en     (cnt_en),
    .running    (running),
    .alarm      (alarm),
    .state_o    (state_o)
  );

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_data(input string tag,
                          input logic [3:0] m,
                          input logic [3:0] t,
                          input logic [3:0] o);
    chk({tag, "_min"},  {4'h0, min_data},  {4'h0, m});
    chk({tag, "_tens"}, {4'h0, tens_data}, {4'h0, t});
    chk({tag, "_ones"}, {4'h0, ones_data}, {4'h0, o});
  endtask

  task automatic quiet();
    clr = 0; tick = 0; start = 0; stop = 0;
    digit_valid = 0; digit = 4'd0;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    quiet();
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    digit = d; digit_valid = 1;
    cyc();
  endtask

  initial begin
    quiet();
    min_zero = 0; tens_zero = 0; ones_zero = 0;

    clr = 1;
    cyc();
    chk("rst_state", {5'd0, state_o}, {5'd0, S_IDLE});
    chk("rst_loadn", {7'd0, loadn}, 8'd1);
    chk("rst_cnt_en", {7'd0, cnt_en}, 8'd0);
    chk("rst_running", {7'd0, running}, 8'd0);
    chk("rst_alarm", {7'd0, alarm}, 8'd0);
    chk_data("rst", 4'd0, 4'd0, 4'd0);

    // entry 1,3,0 and load
    key(4'd1);
    chk("entry_state", {5'd0, state_o}, {5'd0, S_ENTRY});
    key(4'd3);
    key(4'd0);
    start = 1;
    cyc();
    chk("load_state", {5'd0, state_o}, {5'd0, S_LOAD});
    chk("load_loadn", {7'd0, loadn}, 8'd0);
    chk_data("load130", 4'd1, 4'd3, 4'd0);
    cyc();
    chk("run_state", {5'd0, state_o}, {5'd0, S_RUN});
    chk("run_running", {7'd0, running}, 8'd1);
    chk("run_loadn", {7'd0, loadn}, 8'd1);
    chk("run_no_tick", {7'd0, cnt_en}, 8'd0);
    tick = 1;
    #1;
    chk("run_tick", {7'd0, cnt_en}, 8'd1);

    // pause, resume, cancel
    tick = 0; stop = 1;
    cyc();
    chk("pause_state", {5'd0, state_o}, {5'd0, S_PAUSE});
    tick = 1;
    #1;
    chk("pause_cnt_en", {7'd0, cnt_en}, 8'd0);
    tick = 0; start = 1;
    cyc();
    chk("resume_state", {5'd0, state_o}, {5'd0, S_RUN});
    chk("resume_loadn", {7'd0, loadn}, 8'd1);
    stop = 1;
    cyc();
    stop = 1;
    cyc();
    chk("clear_state", {5'd0, state_o}, {5'd0, S_CLEAR});
    chk("clear_loadn", {7'd0, loadn}, 8'd0);
    chk_data("clear", 4'd0, 4'd0, 4'd0);
    cyc();
    chk("clear_idle", {5'd0, state_o}, {5'd0, S_IDLE});

    // clamp and invalid digit
    key(4'd9);
    key(4'd8);
    key(4'd12);
    chk("bad_digit_state", {5'd0, state_o}, {5'd0, S_ENTRY});
    chk_data("bad_digit", 4'd0, 4'd5, 4'd8);
    key(4'd7);
    start = 1;
    cyc();
    chk("clamp_loadn", {7'd0, loadn}, 8'd0);
    chk_data("clamp", 4'd9, 4'd5, 4'd7);
    cyc();

    // count down from 0:01 to 0:00
    min_zero = 1; tens_zero = 1; ones_zero = 0;
    tick = 1;
    #1;
    chk("last_tick", {7'd0, cnt_en}, 8'd1);
    cyc();
    ones_zero = 1;
    #1;
    chk("zero_no_en", {7'd0, cnt_en}, 8'd0);
    chk("zero_still_run", {5'd0, state_o}, {5'd0, S_RUN});
    cyc();
    chk("done_state", {5'd0, state_o}, {5'd0, S_DONE});
    chk("done_alarm", {7'd0, alarm}, 8'd1);
    start = 1;
    cyc();
    chk("done_start_ign", {5'd0, state_o}, {5'd0, S_DONE});
    for (int i = 0; i < 4; i++) begin
      tick = 1;
      #1;
      chk("done_tick_en", {7'd0, cnt_en}, 8'd0);
      cyc();
    end
    chk("alarm_4ticks", {7'd0, alarm}, 8'd1);
    tick = 1;
    cyc();
    chk("alarm_end_state", {5'd0, state_o}, {5'd0, S_IDLE});
    chk("alarm_end", {7'd0, alarm}, 8'd0);
    chk_data("retained", 4'd9, 4'd5, 4'd7);

    // collision in RUN
    min_zero = 0; tens_zero = 0; ones_zero = 0;
    start = 1;
    cyc();
    cyc();
    chk("restart_run", {5'd0, state_o}, {5'd0, S_RUN});
    start = 1; stop = 1;
    cyc();
    chk("coll_run", {5'd0, state_o}, {5'd0, S_PAUSE});
    stop = 1;
    cyc();
    cyc();

    // collision in ENTRY
    key(4'd4);
    chk("coll_pre", {5'd0, state_o}, {5'd0, S_ENTRY});
    start = 1; stop = 1;
    cyc();
    chk("coll_entry", {5'd0, state_o}, {5'd0, S_IDLE});
    chk_data("coll_entry", 4'd0, 4'd0, 4'd0);

    // start with empty entry still loads
    start = 1;
    cyc();
    chk("zero_load", {5'd0, state_o}, {5'd0, S_LOAD});
    stop = 1;
    cyc();
    chk("load_ign_stop", {5'd0, state_o}, {5'd0, S_RUN});
    stop = 1;
    cyc();
    stop = 1;
    cyc();
    cyc();

    // reset mid-run with tick
    key(4'd2);
    start = 1;
    cyc();
    cyc();
    chk("pre_rst_run", {5'd0, state_o}, {5'd0, S_RUN});
    clr = 1; tick = 1;
    cyc();
    tick = 1;
    #1;
    chk("mrst_state", {5'd0, state_o}, {5'd0, S_IDLE});
    chk("mrst_cnt_en", {7'd0, cnt_en}, 8'd0);
    chk("mrst_loadn", {7'd0, loadn}, 8'd1);
    chk("mrst_alarm", {7'd0, alarm}, 8'd0);
    chk_data("mrst", 4'd0, 4'd0, 4'd0);
    tick = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
